// File: rtl/traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl_param
// Purpose  : Parametrised four-approach junction controller. It sequences the
//            main road (M1, M2), the main-road turn (MT) and the side road (S)
//            through fixed-length phases. The side phase is served only on a
//            latched demand, unless SIDE_ALWAYS is set. An all-red clearance
//            phase separates rotations, and a flashing-amber night mode is
//            entered and left only through all-red.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports    : clk       in   system clock, rising edge
//            rst       in   synchronous reset, active-high
//            side_req  in   side-road sensor / pedestrian request
//            flash_en  in   night-mode request (level)
//            light_M1  out  main approach 1 lamp (001 G, 010 A, 100 R, 000 off)
//            light_M2  out  main approach 2 lamp
//            light_MT  out  main turn lamp
//            light_S   out  side road lamp
//            phase_id  out  current phase number (0..7)
// ============================================================================
module traffic_light_ctrl_param #(
    parameter int CW          = 8,
    parameter int T_MAIN      = 7,
    parameter int T_TURN      = 5,
    parameter int T_SIDE      = 3,
    parameter int T_AMB       = 2,
    parameter int T_CLR       = 1,
    parameter int FLASH_T     = 4,
    parameter int SIDE_ALWAYS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       flash_en,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [2:0] phase_id
);

    // Phase encoding. The value is the externally visible phase_id.
    localparam logic [2:0] c_PH_ALL_RED  = 3'd0;
    localparam logic [2:0] c_PH_MAIN_GO  = 3'd1;
    localparam logic [2:0] c_PH_M2_AMB   = 3'd2;
    localparam logic [2:0] c_PH_TURN_GO  = 3'd3;
    localparam logic [2:0] c_PH_TURN_AMB = 3'd4;
    localparam logic [2:0] c_PH_SIDE_GO  = 3'd5;
    localparam logic [2:0] c_PH_SIDE_AMB = 3'd6;
    localparam logic [2:0] c_PH_FLASH    = 3'd7;

    // Lamp encodings
    localparam logic [2:0] c_LT_GREEN = 3'b001;
    localparam logic [2:0] c_LT_AMBER = 3'b010;
    localparam logic [2:0] c_LT_RED   = 3'b100;
    localparam logic [2:0] c_LT_DARK  = 3'b000;

    // Last count value of each phase. The counter runs 0..T-1.
    localparam logic [CW-1:0] c_LAST_MAIN  = CW'(T_MAIN - 1);
    localparam logic [CW-1:0] c_LAST_TURN  = CW'(T_TURN - 1);
    localparam logic [CW-1:0] c_LAST_SIDE  = CW'(T_SIDE - 1);
    localparam logic [CW-1:0] c_LAST_AMB   = CW'(T_AMB - 1);
    localparam logic [CW-1:0] c_LAST_CLR   = CW'(T_CLR - 1);
    localparam logic [CW-1:0] c_LAST_FLASH = CW'(FLASH_T - 1);
    localparam logic          c_SIDE_ALWAYS = (SIDE_ALWAYS != 0);

    // Registered state
    logic [2:0]    r_phase;
    logic [CW-1:0] r_count;
    logic          r_demand;
    logic          r_flash_on;
    logic [2:0]    r_light_M1;
    logic [2:0]    r_light_M2;
    logic [2:0]    r_light_MT;
    logic [2:0]    r_light_S;

    // Next-state values
    logic [2:0]    w_phase_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_demand_nxt;
    logic          w_flash_on_nxt;
    logic [2:0]    w_light_M1_nxt;
    logic [2:0]    w_light_M2_nxt;
    logic [2:0]    w_light_MT_nxt;
    logic [2:0]    w_light_S_nxt;
    logic [CW-1:0] w_last;
    logic          w_phase_end;
    logic          w_side_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= c_PH_ALL_RED;
            r_count    <= '0;
            r_demand   <= 1'b0;
            r_flash_on <= 1'b1;
            r_light_M1 <= c_LT_RED;
            r_light_M2 <= c_LT_RED;
            r_light_MT <= c_LT_RED;
            r_light_S  <= c_LT_RED;
        end else begin
            r_phase    <= w_phase_nxt;
            r_count    <= w_count_nxt;
            r_demand   <= w_demand_nxt;
            r_flash_on <= w_flash_on_nxt;
            r_light_M1 <= w_light_M1_nxt;
            r_light_M2 <= w_light_M2_nxt;
            r_light_MT <= w_light_MT_nxt;
            r_light_S  <= w_light_S_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Phase length lookup
    // ------------------------------------------------------------------
    always_comb begin
        w_last = c_LAST_CLR;
        case (r_phase)
            c_PH_ALL_RED:  w_last = c_LAST_CLR;
            c_PH_MAIN_GO:  w_last = c_LAST_MAIN;
            c_PH_M2_AMB:   w_last = c_LAST_AMB;
            c_PH_TURN_GO:  w_last = c_LAST_TURN;
            c_PH_TURN_AMB: w_last = c_LAST_AMB;
            c_PH_SIDE_GO:  w_last = c_LAST_SIDE;
            c_PH_SIDE_AMB: w_last = c_LAST_AMB;
            c_PH_FLASH:    w_last = c_LAST_FLASH;
            default:       w_last = c_LAST_CLR;
        endcase
    end

    assign w_phase_end = (r_count == w_last);
    assign w_side_busy = (r_phase == c_PH_SIDE_GO) || (r_phase == c_PH_SIDE_AMB);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_nxt    = r_phase;
        w_count_nxt    = r_count + CW'(1);
        w_flash_on_nxt = r_flash_on;
        // Requests arriving while the side road is already being served are
        // dropped; they are not carried over into the next rotation.
        w_demand_nxt   = r_demand | (side_req & ~w_side_busy);

        if (w_phase_end) begin
            w_count_nxt = '0;
            case (r_phase)
                c_PH_ALL_RED:  w_phase_nxt = flash_en ? c_PH_FLASH : c_PH_MAIN_GO;
                c_PH_MAIN_GO:  w_phase_nxt = c_PH_M2_AMB;
                c_PH_M2_AMB:   w_phase_nxt = flash_en ? c_PH_ALL_RED : c_PH_TURN_GO;
                c_PH_TURN_GO:  w_phase_nxt = c_PH_TURN_AMB;
                c_PH_TURN_AMB: begin
                    if (flash_en)
                        w_phase_nxt = c_PH_ALL_RED;
                    else if (r_demand || c_SIDE_ALWAYS)
                        w_phase_nxt = c_PH_SIDE_GO;
                    else
                        w_phase_nxt = c_PH_ALL_RED;
                end
                c_PH_SIDE_GO:  w_phase_nxt = c_PH_SIDE_AMB;
                c_PH_SIDE_AMB: w_phase_nxt = c_PH_ALL_RED;
                c_PH_FLASH: begin
                    // flash_en is only looked at when a half-period ends
                    if (flash_en)
                        w_flash_on_nxt = ~r_flash_on;
                    else
                        w_phase_nxt = c_PH_ALL_RED;
                end
                default:       w_phase_nxt = c_PH_ALL_RED;
            endcase
        end

        // Every entry into night mode begins with the lamps lit
        if ((w_phase_nxt == c_PH_FLASH) && (r_phase != c_PH_FLASH))
            w_flash_on_nxt = 1'b1;

        // Serving the side road consumes the demand; this wins over a
        // request arriving on the same edge.
        if ((w_phase_nxt == c_PH_SIDE_GO) && (r_phase != c_PH_SIDE_GO))
            w_demand_nxt = 1'b0;
    end

    // ------------------------------------------------------------------
    // Lamp decode from the next phase, so lamps change on the same edge
    // as the phase itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_light_M1_nxt = c_LT_RED;
        w_light_M2_nxt = c_LT_RED;
        w_light_MT_nxt = c_LT_RED;
        w_light_S_nxt  = c_LT_RED;
        case (w_phase_nxt)
            c_PH_MAIN_GO: begin
                w_light_M1_nxt = c_LT_GREEN;
                w_light_M2_nxt = c_LT_GREEN;
            end
            c_PH_M2_AMB: begin
                w_light_M1_nxt = c_LT_GREEN;
                w_light_M2_nxt = c_LT_AMBER;
            end
            c_PH_TURN_GO: begin
                w_light_M1_nxt = c_LT_GREEN;
                w_light_MT_nxt = c_LT_GREEN;
            end
            c_PH_TURN_AMB: begin
                w_light_M1_nxt = c_LT_AMBER;
                w_light_MT_nxt = c_LT_AMBER;
            end
            c_PH_SIDE_GO:  w_light_S_nxt = c_LT_GREEN;
            c_PH_SIDE_AMB: w_light_S_nxt = c_LT_AMBER;
            c_PH_FLASH: begin
                w_light_M1_nxt = w_flash_on_nxt ? c_LT_AMBER : c_LT_DARK;
                w_light_M2_nxt = w_flash_on_nxt ? c_LT_AMBER : c_LT_DARK;
                w_light_MT_nxt = w_flash_on_nxt ? c_LT_AMBER : c_LT_DARK;
                w_light_S_nxt  = w_flash_on_nxt ? c_LT_AMBER : c_LT_DARK;
            end
            default: begin
                w_light_M1_nxt = c_LT_RED;
                w_light_M2_nxt = c_LT_RED;
                w_light_MT_nxt = c_LT_RED;
                w_light_S_nxt  = c_LT_RED;
            end
        endcase
    end

    assign light_M1 = r_light_M1;
    assign light_M2 = r_light_M2;
    assign light_MT = r_light_MT;
    assign light_S  = r_light_S;
    assign phase_id = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl_param
// Purpose  : Bench for traffic_light_ctrl_param. Two instances share the
//            inputs: one serves the side road on demand, the other always.
//            A countdown model of the phase rules predicts phase, lamps and
//            the demand latch for each instance on every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl_param;

    localparam int c_T_MAIN  = 4;
    localparam int c_T_TURN  = 3;
    localparam int c_T_SIDE  = 3;
    localparam int c_T_AMB   = 2;
    localparam int c_T_CLR   = 1;
    localparam int c_FLASH_T = 2;

    logic       clk;
    logic       rst;
    logic       side_req;
    logic       flash_en;
    logic [2:0] w_m1_a, w_m2_a, w_mt_a, w_s_a, w_ph_a;
    logic [2:0] w_m1_b, w_m2_b, w_mt_b, w_s_b, w_ph_b;

    traffic_light_ctrl_param #(
        .CW(8), .T_MAIN(c_T_MAIN), .T_TURN(c_T_TURN), .T_SIDE(c_T_SIDE),
        .T_AMB(c_T_AMB), .T_CLR(c_T_CLR), .FLASH_T(c_FLASH_T), .SIDE_ALWAYS(0)
    ) dut_a (
        .clk(clk), .rst(rst), .side_req(side_req), .flash_en(flash_en),
        .light_M1(w_m1_a), .light_M2(w_m2_a), .light_MT(w_mt_a),
        .light_S(w_s_a), .phase_id(w_ph_a)
    );

    traffic_light_ctrl_param #(
        .CW(8), .T_MAIN(c_T_MAIN), .T_TURN(c_T_TURN), .T_SIDE(c_T_SIDE),
        .T_AMB(c_T_AMB), .T_CLR(c_T_CLR), .FLASH_T(c_FLASH_T), .SIDE_ALWAYS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .side_req(side_req), .flash_en(flash_en),
        .light_M1(w_m1_b), .light_M2(w_m2_b), .light_MT(w_mt_b),
        .light_S(w_s_b), .phase_id(w_ph_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: phase number, cycles left in it, demand, lit half
    int m_ph   [2];
    int m_left [2];
    bit m_dem  [2];
    bit m_on   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            0: return c_T_CLR;
            1: return c_T_MAIN;
            2: return c_T_AMB;
            3: return c_T_TURN;
            4: return c_T_AMB;
            5: return c_T_SIDE;
            6: return c_T_AMB;
            default: return c_FLASH_T;
        endcase
    endfunction

    // Lamp table {M1, M2, MT, S}
    function automatic logic [11:0] lamps(input int ph, input bit on);
        case (ph)
            0: return {3'b100, 3'b100, 3'b100, 3'b100};
            1: return {3'b001, 3'b001, 3'b100, 3'b100};
            2: return {3'b001, 3'b010, 3'b100, 3'b100};
            3: return {3'b001, 3'b100, 3'b001, 3'b100};
            4: return {3'b010, 3'b100, 3'b010, 3'b100};
            5: return {3'b100, 3'b100, 3'b100, 3'b001};
            6: return {3'b100, 3'b100, 3'b100, 3'b010};
            default: return on ? {4{3'b010}} : 12'h000;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs as they are now
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k] = 0; m_left[k] = c_T_CLR; m_dem[k] = 0; m_on[k] = 1;
            end else begin
                bit set_ok;
                int nx;
                bit enter;
                set_ok = side_req && (m_ph[k] != 5) && (m_ph[k] != 6);
                nx     = m_ph[k];
                enter  = 0;
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    enter = 1;
                    case (m_ph[k])
                        0: nx = flash_en ? 7 : 1;
                        1: nx = 2;
                        2: nx = flash_en ? 0 : 3;
                        3: nx = 4;
                        4: nx = flash_en ? 0 : ((m_dem[k] || k == 1) ? 5 : 0);
                        5: nx = 6;
                        6: nx = 0;
                        default: begin
                            if (flash_en) begin
                                enter = 0;
                                m_on[k] = !m_on[k];
                                m_left[k] = c_FLASH_T;
                            end else begin
                                nx = 0;
                            end
                        end
                    endcase
                end
                if (enter) begin
                    m_ph[k] = nx;
                    m_left[k] = dur(nx);
                    if (nx == 7) m_on[k] = 1;
                end
                if (enter && nx == 5) m_dem[k] = 0;
                else if (set_ok) m_dem[k] = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("phase_a", {29'd0, w_ph_a}, m_ph[0]);
        check("lamps_a", {20'd0, w_m1_a, w_m2_a, w_mt_a, w_s_a}, {20'd0, lamps(m_ph[0], m_on[0])});
        check("demand_a", {31'd0, dut_a.r_demand}, {31'd0, m_dem[0]});
        check("phase_b", {29'd0, w_ph_b}, m_ph[1]);
        check("lamps_b", {20'd0, w_m1_b, w_m2_b, w_mt_b, w_s_b}, {20'd0, lamps(m_ph[1], m_on[1])});
        check("demand_b", {31'd0, dut_b.r_demand}, {31'd0, m_dem[1]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until instance A's model is in phase ph with left cycles remaining
    task automatic run_until(input int ph, input int left, input int limit);
        int n;
        n = 0;
        while (!(m_ph[0] == ph && m_left[0] == left) && n < limit) begin
            step();
            n++;
        end
        check("wait_reached", {31'd0, (m_ph[0] == ph && m_left[0] == left)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; side_req = 1'b0; flash_en = 1'b0;
        step();
        check("reset_phase", {29'd0, w_ph_a}, 32'd0);
        check("reset_lamps", {20'd0, w_m1_a, w_m2_a, w_mt_a, w_s_a}, {20'd0, 12'b100_100_100_100});
        rst = 1'b0;

        // Plain rotation, no side demand
        run(30);

        // Side request pulse in MAIN_GO, then a rotation without demand
        run_until(1, 2, 40);
        side_req = 1'b1; step(); side_req = 1'b0;
        run(32);

        // Request held through the side phase and dropped at its end
        run_until(1, 3, 40);
        side_req = 1'b1; step();
        run_until(6, 1, 40);
        step(); side_req = 1'b0;
        run(20);

        // Night mode raised mid TURN_GO, then dropped
        run_until(3, 2, 40);
        flash_en = 1'b1;
        run(16);
        flash_en = 1'b0;
        run(10);

        // Reset in the second cycle of SIDE_GO with a request pending
        run_until(1, 2, 40);
        side_req = 1'b1; step(); side_req = 1'b0;
        run_until(5, c_T_SIDE - 1, 40);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_phase", {29'd0, w_ph_a}, 32'd0);
        run(14);

        // Request coinciding with the SIDE_GO entry edge
        run_until(1, 2, 40);
        side_req = 1'b1; step(); side_req = 1'b0;
        run_until(4, 1, 40);
        side_req = 1'b1; step(); side_req = 1'b0;
        check("demand_clear_wins", {31'd0, dut_a.r_demand}, 32'd0);
        run(30);

        // Randomised traffic, night mode and occasional reset
        for (int i = 0; i < 1500; i++) begin
            side_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) flash_en = ~flash_en;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
